axi_mem_slave: RTL and testbench
================================

# axi_mem_slave

AXI4 subordinate front-end that turns AXI4 write and read bursts into word accesses on the `mem_simple` port pair. It sits between the interconnect under throughput test and the memory. Write and read paths are independent FSMs that can run concurrently, each with one outstanding burst. After the first beat, both paths sustain one beat per cycle.

## Interface

**Parameters**
- `ADDR_WIDTH`, default 10: word-address bits of the memory.
- `DATA_WIDTH`, default 32: data bus width. Must be 32, 64 or 128.
- `AXI_ADDR_WIDTH`, default 32: AXI byte-address width.
- `ID_WIDTH`, default 4: AXI ID width.

**Ports** (`AW` = `AXI_ADDR_WIDTH`, `DW` = `DATA_WIDTH`, `SW` = `DW/8`)
- `clk`, in, 1: single clock.
- `rst_n`, in, 1: asynchronous, active-low reset.
- AW channel inputs: `awid` [ID_WIDTH], `awaddr` [AW], `awlen` [8], `awsize` [3], `awburst` [2], `awvalid` [1]. Output: `awready` [1].
- W channel inputs: `wdata` [DW], `wstrb` [SW], `wlast` [1], `wvalid` [1]. Output: `wready` [1].
- B channel outputs: `bid` [ID_WIDTH], `bresp` [2], `bvalid` [1]. Input: `bready` [1].
- AR channel inputs: `arid`, `araddr`, `arlen`, `arsize`, `arburst`, `arvalid`, with widths as on AW. Output: `arready` [1].
- R channel outputs: `rid` [ID_WIDTH], `rdata` [DW], `rresp` [2], `rlast` [1], `rvalid` [1]. Input: `rready` [1].
- `mem_we`, `mem_waddr` [ADDR_WIDTH], `mem_wdata` [DW], `mem_wstrb` [SW]: out, memory write port.
- `mem_rd`, `mem_raddr` [ADDR_WIDTH]: out, memory read port.
- `mem_rdata`, in, [DW]: read data. Valid one cycle after `mem_rd` and held until the next `mem_rd`.

## Operation

**Address translation**
- Word address = `Axaddr[ADDR_WIDTH+log2(SW)-1 : log2(SW)]`. Upper bits are ignored.
- INCR and WRAP bursts increment the word address by 1 per beat, wrapping modulo 2^ADDR_WIDTH. WRAP is treated as INCR.
- FIXED bursts hold the address for every beat.

**Size check**
- `Axsize` != log2(SW) is an error burst. All beats are still transferred.
- On a write error burst, `mem_we` stays 0 for the whole burst and `bresp` = SLVERR.
- On a read error burst, `rresp` = SLVERR on every beat.
- Otherwise the response is OKAY.

**Write FSM**
- `W_IDLE`: `awready` = 1. AW handshake latches id, address, len, burst and the error flag, then goes to `W_DATA`.
- `W_DATA`: `wready` = 1.
  - Each W handshake drives `mem_we` = !err, `mem_waddr` = current address, and passes `mem_wdata`/`mem_wstrb` through combinationally.
  - The beat counter decrements on each handshake. The handshake with count == 0 goes to `W_RESP`.
  - If `wlast` disagrees with count == 0 on any beat, the error flag is set (SLVERR). Length is always taken from `awlen`.
- `W_RESP`: `bvalid` = 1 and `bid` is the latched id. The B handshake returns to `W_IDLE`.

**Read FSM**
- `R_IDLE`: `arready` = 1. AR handshake latches the burst fields, then goes to `R_BURST`.
- `R_BURST`:
  - `mem_rd` = (beats issued <= arlen) && (!rvalid || rready), with `mem_raddr` = current address.
  - `rvalid` is set the cycle after `mem_rd`. It is cleared on an R handshake that has no new `mem_rd` behind it.
  - `rlast` is registered alongside each issued beat.
  - The R handshake with `rlast` = 1 returns to `R_IDLE`.
- `rdata` = `mem_rdata` directly. No data buffering is needed, because `mem_rd` fires only when the previous beat is consumed.

## Timing

**Reset values**
- All registered outputs are 0 during reset: `bvalid`, `rvalid`, `rlast`, `bresp`, `rresp`, `bid`, `rid`.
- `mem_we` and `mem_rd` are 0 during reset.
- Both FSMs reset to IDLE.

**Ready signals**
- `awready` and `arready` are combinational decodes of the IDLE states. They are gated by `rst_n`, so they are 0 during reset and 1 on the first cycle after reset.

**Latencies**
- AW handshake at cycle t: `wready` = 1 at t+1.
- Last W handshake at t: `bvalid` = 1 at t+1.
- AR handshake at t: `mem_rd` at t+1, `rvalid` at t+2.
- Without backpressure, beat k of a read is presented at t+2+k.

**Boundary conditions**
- The next AW or AR is accepted no earlier than the cycle after the B or final R handshake.
- Read and write to the same word in the same cycle: the read returns the old data.
- `rready` low stalls reads. `rdata` is held because `mem_rd` stays 0.
- Reset asserted mid-burst aborts immediately. No further `mem_we` occurs and no response is issued.

## Structure

**Package `axi_mem_pkg`**
- `burst_t` (FIXED=0, INCR=1, WRAP=2).
- `resp_t` (OKAY=0, SLVERR=2).
- `wstate_t` and `rstate_t` enums.

**Sub-module**
- `axi_burst_addr`: next-address calculation (FIXED hold / INCR increment / modulo wrap).
- Instantiated once per channel.

## Test plan

- **Single write:** AW addr 0x10, len 0, strb 0xF, data 0xDEADBEEF. Then single read of 0x10. Expect `mem_waddr` = 4, bresp OKAY, rdata 0xDEADBEEF, rlast = 1.
- **Back-to-back burst:** INCR len 15 write then read at 0x0, `rready` held at 1. Expect 16 consecutive W beats, with 16 R beats in consecutive cycles t+2..t+17 and `rlast` only on the last.
- **Read backpressure:** `rready` toggles 1,0,0,1,… during a len-7 read. Expect `rdata` stable while stalled, no extra `mem_rd` pulses, and all 8 values in order.
- **Corner cases:** FIXED burst len 3 writes to one word, so the last beat's data persists. INCR starting at word 1023 wraps to word 0.
- **Error bursts:** `awsize` = 1 gives zero `mem_we` pulses and bresp SLVERR. Early `wlast` on beat 2 of a len-3 write gives 4 beats accepted and bresp SLVERR.
- **Reset mid-burst:** `rst_n` pulsed low during beat 5 of a write. Expect `bvalid`/`mem_we` to drop immediately and `awready` = 1 on the cycle after release.

Source files
------------

// File: rtl/axi_mem_pkg.sv
// rtl/axi_mem_pkg.sv - shared burst/response/state types for the AXI memory subordinate
package axi_mem_pkg;

    typedef enum logic [1:0] {
        FIXED = 2'd0,
        INCR  = 2'd1,
        WRAP  = 2'd2
    } burst_t;

    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        SLVERR = 2'd2
    } resp_t;

    typedef enum logic [1:0] {
        W_IDLE,
        W_DATA,
        W_RESP
    } wstate_t;

    typedef enum logic {
        R_IDLE,
        R_BURST
    } rstate_t;

    function automatic resp_t err_resp(input logic err);
        return err ? SLVERR : OKAY;
    endfunction

endpackage

// File: rtl/axi_burst_addr.sv
// rtl/axi_burst_addr.sv - next word address for one burst beat
// Ports: addr (current word address), burst (burst type), next_addr (address of the following beat).
module axi_burst_addr
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH = 10
) (
    input  logic [ADDR_WIDTH-1:0] addr,
    input  burst_t                burst,
    output logic [ADDR_WIDTH-1:0] next_addr
);

    // WRAP deliberately follows INCR; the increment wraps modulo the memory size.
    always_comb begin
        next_addr = addr + ADDR_WIDTH'(1);
        if (burst == FIXED) begin
            next_addr = addr;
        end
    end

endmodule

// File: rtl/axi_mem_slave.sv
// rtl/axi_mem_slave.sv - AXI4 subordinate turning write/read bursts into word accesses on a simple memory port
// Ports: clk/rst_n; AXI4 AW, W, B, AR, R channels; mem_we/mem_waddr/mem_wdata/mem_wstrb write port;
//        mem_rd/mem_raddr read request and mem_rdata (valid one cycle after mem_rd, held until the next).
module axi_mem_slave
    import axi_mem_pkg::*;
#(
    parameter int ADDR_WIDTH     = 10,
    parameter int DATA_WIDTH     = 32,
    parameter int AXI_ADDR_WIDTH = 32,
    parameter int ID_WIDTH       = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [ID_WIDTH-1:0]         awid,
    input  logic [AXI_ADDR_WIDTH-1:0]   awaddr,
    input  logic [7:0]                  awlen,
    input  logic [2:0]                  awsize,
    input  logic [1:0]                  awburst,
    input  logic                        awvalid,
    output logic                        awready,
    input  logic [DATA_WIDTH-1:0]       wdata,
    input  logic [DATA_WIDTH/8-1:0]     wstrb,
    input  logic                        wlast,
    input  logic                        wvalid,
    output logic                        wready,
    output logic [ID_WIDTH-1:0]         bid,
    output logic [1:0]                  bresp,
    output logic                        bvalid,
    input  logic                        bready,
    input  logic [ID_WIDTH-1:0]         arid,
    input  logic [AXI_ADDR_WIDTH-1:0]   araddr,
    input  logic [7:0]                  arlen,
    input  logic [2:0]                  arsize,
    input  logic [1:0]                  arburst,
    input  logic                        arvalid,
    output logic                        arready,
    output logic [ID_WIDTH-1:0]         rid,
    output logic [DATA_WIDTH-1:0]       rdata,
    output logic [1:0]                  rresp,
    output logic                        rlast,
    output logic                        rvalid,
    input  logic                        rready,
    output logic                        mem_we,
    output logic [ADDR_WIDTH-1:0]       mem_waddr,
    output logic [DATA_WIDTH-1:0]       mem_wdata,
    output logic [DATA_WIDTH/8-1:0]     mem_wstrb,
    output logic                        mem_rd,
    output logic [ADDR_WIDTH-1:0]       mem_raddr,
    input  logic [DATA_WIDTH-1:0]       mem_rdata
);

    localparam int         LSB       = $clog2(DATA_WIDTH / 8);
    localparam logic [2:0] SIZE_FULL = 3'(LSB);

    // Byte-lane and upper address bits carry no meaning for a word memory.
    logic unused_addr_bits;
    assign unused_addr_bits = ^{awaddr, araddr};

    // ---------------- write path ----------------
    wstate_t                 wstate;
    logic [ID_WIDTH-1:0]     w_id;
    logic [ADDR_WIDTH-1:0]   w_addr;
    logic [ADDR_WIDTH-1:0]   w_addr_next;
    logic [7:0]              w_cnt;
    burst_t                  w_burst;
    logic                    w_err;
    logic                    w_hs;
    logic                    w_last_beat;
    logic                    w_len_err;

    assign awready     = rst_n && (wstate == W_IDLE);
    assign wready      = (wstate == W_DATA);
    assign w_hs        = wvalid && wready;
    assign w_last_beat = (w_cnt == 8'd0);
    assign w_len_err   = (wlast != w_last_beat);

    // Error bursts still consume every beat but never touch memory.
    assign mem_we    = w_hs && !w_err;
    assign mem_waddr = w_addr;
    assign mem_wdata = wdata;
    assign mem_wstrb = wstrb;

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_waddr (
        .addr      (w_addr),
        .burst     (w_burst),
        .next_addr (w_addr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wstate  <= W_IDLE;
            w_id    <= '0;
            w_addr  <= '0;
            w_cnt   <= '0;
            w_burst <= INCR;
            w_err   <= 1'b0;
            bvalid  <= 1'b0;
            bresp   <= OKAY;
            bid     <= '0;
        end else begin
            case (wstate)
                W_IDLE: begin
                    if (awvalid) begin
                        w_id    <= awid;
                        w_addr  <= awaddr[ADDR_WIDTH+LSB-1:LSB];
                        w_cnt   <= awlen;
                        w_burst <= burst_t'(awburst);
                        w_err   <= (awsize != SIZE_FULL);
                        wstate  <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_addr <= w_addr_next;
                        w_cnt  <= w_cnt - 8'd1;
                        // Length comes from awlen only; a misplaced wlast just poisons the response.
                        if (w_last_beat) begin
                            wstate <= W_RESP;
                            bvalid <= 1'b1;
                            bid    <= w_id;
                            bresp  <= err_resp(w_err || w_len_err);
                        end else if (w_len_err) begin
                            w_err <= 1'b1;
                        end
                    end
                end
                W_RESP: begin
                    if (bready) begin
                        bvalid <= 1'b0;
                        wstate <= W_IDLE;
                    end
                end
                default: wstate <= W_IDLE;
            endcase
        end
    end

    // ---------------- read path ----------------
    rstate_t                 rstate;
    logic [ID_WIDTH-1:0]     r_id;
    logic [ADDR_WIDTH-1:0]   r_addr;
    logic [ADDR_WIDTH-1:0]   r_addr_next;
    logic [7:0]              r_len;
    logic [8:0]              r_issued;
    burst_t                  r_burst;
    logic                    r_err;
    logic                    r_more;

    assign arready = rst_n && (rstate == R_IDLE);
    assign r_more  = (r_issued <= {1'b0, r_len});

    // A new read is issued only once the presented beat is (being) consumed,
    // so mem_rdata itself is the R data and never needs a skid buffer.
    assign mem_rd    = (rstate == R_BURST) && r_more && (!rvalid || rready);
    assign mem_raddr = r_addr;
    assign rdata     = mem_rdata;

    axi_burst_addr #(.ADDR_WIDTH(ADDR_WIDTH)) u_raddr (
        .addr      (r_addr),
        .burst     (r_burst),
        .next_addr (r_addr_next)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rstate   <= R_IDLE;
            r_id     <= '0;
            r_addr   <= '0;
            r_len    <= '0;
            r_issued <= '0;
            r_burst  <= INCR;
            r_err    <= 1'b0;
            rvalid   <= 1'b0;
            rlast    <= 1'b0;
            rresp    <= OKAY;
            rid      <= '0;
        end else begin
            case (rstate)
                R_IDLE: begin
                    if (arvalid) begin
                        r_id     <= arid;
                        r_addr   <= araddr[ADDR_WIDTH+LSB-1:LSB];
                        r_len    <= arlen;
                        r_issued <= '0;
                        r_burst  <= burst_t'(arburst);
                        r_err    <= (arsize != SIZE_FULL);
                        rstate   <= R_BURST;
                    end
                end
                R_BURST: begin
                    if (mem_rd) begin
                        r_addr   <= r_addr_next;
                        r_issued <= r_issued + 9'd1;
                        rvalid   <= 1'b1;
                        rlast    <= (r_issued == {1'b0, r_len});
                        rresp    <= err_resp(r_err);
                        rid      <= r_id;
                    end else if (rvalid && rready) begin
                        rvalid <= 1'b0;
                        rlast  <= 1'b0;
                    end
                    if (rvalid && rready && rlast) begin
                        rstate <= R_IDLE;
                    end
                end
                default: rstate <= R_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_axi_mem_slave.sv
// tb/tb_axi_mem_slave.sv - directed scoreboard bench for axi_mem_slave
module tb_axi_mem_slave;

    localparam int AW = 10;
    localparam int DW = 32;
    localparam int SW = 4;
    localparam int IW = 4;

    logic          clk = 1'b0;
    logic          rst_n = 1'b0;
    logic [IW-1:0] awid, arid, bid, rid;
    logic [31:0]   awaddr, araddr;
    logic [7:0]    awlen, arlen;
    logic [2:0]    awsize, arsize;
    logic [1:0]    awburst, arburst, bresp, rresp;
    logic          awvalid, awready, wlast, wvalid, wready, bvalid, bready;
    logic          arvalid, arready, rlast, rvalid, rready;
    logic [DW-1:0] wdata, rdata, mem_wdata, mem_rdata;
    logic [SW-1:0] wstrb, mem_wstrb;
    logic          mem_we, mem_rd;
    logic [AW-1:0] mem_waddr, mem_raddr;

    axi_mem_slave #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW), .AXI_ADDR_WIDTH(32), .ID_WIDTH(IW)) dut (
        .clk(clk), .rst_n(rst_n),
        .awid(awid), .awaddr(awaddr), .awlen(awlen), .awsize(awsize), .awburst(awburst),
        .awvalid(awvalid), .awready(awready),
        .wdata(wdata), .wstrb(wstrb), .wlast(wlast), .wvalid(wvalid), .wready(wready),
        .bid(bid), .bresp(bresp), .bvalid(bvalid), .bready(bready),
        .arid(arid), .araddr(araddr), .arlen(arlen), .arsize(arsize), .arburst(arburst),
        .arvalid(arvalid), .arready(arready),
        .rid(rid), .rdata(rdata), .rresp(rresp), .rlast(rlast), .rvalid(rvalid), .rready(rready),
        .mem_we(mem_we), .mem_waddr(mem_waddr), .mem_wdata(mem_wdata), .mem_wstrb(mem_wstrb),
        .mem_rd(mem_rd), .mem_raddr(mem_raddr), .mem_rdata(mem_rdata)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    // Memory behind the DUT: read-before-write, data held until next mem_rd.
    logic [DW-1:0] mem_array [0:1023];
    always @(posedge clk) begin
        if (mem_rd) mem_rdata <= mem_array[mem_raddr];
        if (mem_we) begin
            for (int b = 0; b < SW; b++)
                if (mem_wstrb[b]) mem_array[mem_waddr][b*8 +: 8] <= mem_wdata[b*8 +: 8];
        end
    end

    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
        logic [SW-1:0] strb;
    } wexp_t;

    typedef struct packed {
        logic [DW-1:0] data;
        logic [1:0]    resp;
        logic          last;
        logic [IW-1:0] id;
    } rexp_t;

    wexp_t         wq[$];
    rexp_t         rq[$];
    logic [DW-1:0] ref_mem [0:1023];
    int            n_cmp = 0;
    int            n_bad = 0;
    logic          we_ignore = 1'b0;
    int            r_total = 0;
    int            r_last_cyc = 0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Scoreboard consumers: memory writes and R beats.
    always @(negedge clk) begin : monitor
        wexp_t we;
        rexp_t re;
        if (rst_n && mem_we && !we_ignore) begin
            if (wq.size() == 0) begin
                check("unexpected_mem_we", {54'd0, mem_waddr}, 64'hFFFF);
            end else begin
                we = wq.pop_front();
                check("mem_waddr", 64'(mem_waddr), 64'(we.addr));
                check("mem_wdata", 64'(mem_wdata), 64'(we.data));
                check("mem_wstrb", 64'(mem_wstrb), 64'(we.strb));
            end
        end
        if (rvalid && rready) begin
            if (rq.size() == 0) begin
                check("unexpected_rbeat", 64'(rdata), 64'hFFFF_FFFF_FFFF);
            end else begin
                re = rq.pop_front();
                check("rdata", 64'(rdata), 64'(re.data));
                check("rresp", 64'(rresp), 64'(re.resp));
                check("rlast", 64'(rlast), 64'(re.last));
                check("rid", 64'(rid), 64'(re.id));
            end
            r_total    <= r_total + 1;
            r_last_cyc <= cyc;
        end
    end

    task automatic axi_write(input logic [31:0] addr, input int len, input logic [2:0] size,
                             input logic [1:0] burst, input logic [IW-1:0] id, input logic [31:0] base,
                             input int early, input logic exp_err, input logic do_mem);
        logic [AW-1:0] wa;
        logic [31:0]   d;
        bit            ok;
        wa = addr[11:2];
        @(posedge clk); #1;
        awvalid = 1'b1; awid = id; awaddr = addr; awlen = 8'(len); awsize = size; awburst = burst;
        ok = 1'b0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (awready) begin ok = 1'b1; break; end
        end
        check("aw_accept", 64'(ok), 64'd1);
        if (!ok) begin awvalid = 1'b0; return; end
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= len; k++) begin
            d = base + 32'(k);
            wvalid = 1'b1; wdata = d; wstrb = '1;
            wlast = (early >= 0) ? (k == early) : (k == len);
            if (do_mem) begin
                wq.push_back('{wa, d, 4'hF});
                ref_mem[wa] = d;
            end
            if (burst != 2'd0) wa = wa + 10'd1;
            @(negedge clk);
            if (k == 0) check("aw_to_wready", 64'(wready), 64'd1);
            ok = wready;
            for (int i = 0; i < 50 && !ok; i++) begin
                @(negedge clk);
                ok = wready;
            end
            if (!ok) begin
                check("w_accept", 64'(ok), 64'd1);
                wvalid = 1'b0;
                return;
            end
            @(posedge clk); #1;
        end
        wvalid = 1'b0; wlast = 1'b0; bready = 1'b1;
        @(negedge clk);
        check("wlast_to_bvalid", 64'(bvalid), 64'd1);
        check("bresp", 64'(bresp), exp_err ? 64'd2 : 64'd0);
        check("bid", 64'(bid), 64'(id));
        @(posedge clk); #1;
        bready = 1'b0;
        @(negedge clk);
        check("bvalid_cleared", 64'(bvalid), 64'd0);
        check("awready_after_b", 64'(awready), 64'd1);
    endtask

    task automatic axi_read(input logic [31:0] addr, input int len, input logic [2:0] size,
                            input logic [1:0] burst, input logic [IW-1:0] id, input logic exp_err,
                            input logic bp);
        logic [AW-1:0] ra;
        logic [DW-1:0] held;
        logic          was_stalled;
        int            ar_cyc, tot0, s;
        bit            ok;
        ra = addr[11:2];
        for (int k = 0; k <= len; k++) begin
            rq.push_back('{ref_mem[ra], exp_err ? 2'd2 : 2'd0, (k == len), id});
            if (burst != 2'd0) ra = ra + 10'd1;
        end
        @(posedge clk); #1;
        arvalid = 1'b1; arid = id; araddr = addr; arlen = 8'(len); arsize = size; arburst = burst;
        rready = 1'b1;
        ok = 1'b0;
        ar_cyc = 0;
        for (int i = 0; i < 50; i++) begin
            @(negedge clk);
            if (arready) begin ok = 1'b1; ar_cyc = cyc; break; end
        end
        check("ar_accept", 64'(ok), 64'd1);
        tot0 = r_total;
        @(posedge clk); #1;
        arvalid = 1'b0;
        @(negedge clk);
        check("ar_to_mem_rd", 64'(mem_rd), 64'd1);
        check("mem_raddr_first", 64'(mem_raddr), 64'(addr[11:2]));
        s = 0;
        was_stalled = 1'b0;
        held = '0;
        for (int i = 0; i < 400; i++) begin
            @(posedge clk); #1;
            rready = bp ? ((s % 4 == 0) || (s % 4 == 3)) : 1'b1;
            s++;
            @(negedge clk); #1;
            if (i == 0) begin
                check("mem_rd_to_rvalid", 64'(rvalid), 64'd1);
                if (!bp) check("first_beat_cycle", 64'(r_total - tot0), 64'd1);
            end
            if (bp && rvalid && !rready) begin
                check("stall_no_mem_rd", 64'(mem_rd), 64'd0);
                if (was_stalled) check("stall_rdata_hold", 64'(rdata), 64'(held));
                held = rdata;
                was_stalled = 1'b1;
            end else begin
                was_stalled = 1'b0;
            end
            if (r_total - tot0 > len) break;
        end
        check("r_beat_count", 64'(r_total - tot0), 64'(len + 1));
        if (!bp) check("last_beat_cycle", 64'(r_last_cyc), 64'(ar_cyc + 2 + len));
        @(posedge clk); #1;
        @(negedge clk);
        check("rvalid_cleared", 64'(rvalid), 64'd0);
        check("arready_after_r", 64'(arready), 64'd1);
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        awid = '0; awaddr = '0; awlen = '0; awsize = '0; awburst = '0; awvalid = 1'b0;
        wdata = '0; wstrb = '0; wlast = 1'b0; wvalid = 1'b0; bready = 1'b0;
        arid = '0; araddr = '0; arlen = '0; arsize = '0; arburst = '0; arvalid = 1'b0;
        rready = 1'b0;
        rst_n = 1'b0;

        repeat (3) @(negedge clk);
        check("rst_awready", 64'(awready), 64'd0);
        check("rst_arready", 64'(arready), 64'd0);
        check("rst_bvalid", 64'(bvalid), 64'd0);
        check("rst_rvalid", 64'(rvalid), 64'd0);
        check("rst_rlast", 64'(rlast), 64'd0);
        check("rst_mem_we", 64'(mem_we), 64'd0);
        check("rst_mem_rd", 64'(mem_rd), 64'd0);
        check("rst_resp_ids", {56'd0, bresp, rresp, bid}, 64'd0);
        check("rst_rid", 64'(rid), 64'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        @(negedge clk);
        check("awready_after_reset", 64'(awready), 64'd1);
        check("arready_after_reset", 64'(arready), 64'd1);

        // Single write then read of byte address 0x10 (word 4).
        axi_write(32'h10, 0, 3'd2, 2'd1, 4'd3, 32'hDEADBEEF, -1, 1'b0, 1'b1);
        axi_read(32'h10, 0, 3'd2, 2'd1, 4'd3, 1'b0, 1'b0);

        // Sixteen-beat INCR burst, no backpressure.
        axi_write(32'h0, 15, 3'd2, 2'd1, 4'd1, 32'h1000_0000, -1, 1'b0, 1'b1);
        axi_read(32'h0, 15, 3'd2, 2'd1, 4'd2, 1'b0, 1'b0);

        // Eight-beat read under rready pattern 1,0,0,1.
        axi_read(32'h0, 7, 3'd2, 2'd1, 4'd4, 1'b0, 1'b1);

        // FIXED burst: last beat persists in word 64.
        axi_write(32'h100, 3, 3'd2, 2'd0, 4'd5, 32'hA000_00A0, -1, 1'b0, 1'b1);
        axi_read(32'h100, 0, 3'd2, 2'd1, 4'd5, 1'b0, 1'b0);

        // INCR from word 1023 wraps to word 0; WRAP burst type on the read behaves as INCR.
        axi_write(32'hFFC, 3, 3'd2, 2'd1, 4'd6, 32'hC0DE_0000, -1, 1'b0, 1'b1);
        axi_read(32'hFFC, 3, 3'd2, 2'd2, 4'd6, 1'b0, 1'b0);

        // Size errors: no memory writes, SLVERR on B and on every R beat.
        axi_write(32'h200, 1, 3'd1, 2'd1, 4'd7, 32'hBAD0_0000, -1, 1'b1, 1'b0);
        axi_read(32'h0, 1, 3'd1, 2'd1, 4'd8, 1'b1, 1'b0);

        // Early wlast on beat 2 of a len-3 write: all 4 beats accepted, SLVERR.
        we_ignore = 1'b1;
        axi_write(32'h300, 3, 3'd2, 2'd1, 4'd9, 32'hEEEE_0000, 2, 1'b1, 1'b0);
        we_ignore = 1'b0;

        // Reset pulsed while beat 5 of an 8-beat write is presented.
        @(posedge clk); #1;
        awvalid = 1'b1; awid = 4'd10; awaddr = 32'h400; awlen = 8'd7; awsize = 3'd2; awburst = 2'd1;
        @(negedge clk);
        check("rst_test_awready", 64'(awready), 64'd1);
        @(posedge clk); #1;
        awvalid = 1'b0;
        for (int k = 0; k <= 5; k++) begin
            wvalid = 1'b1; wdata = 32'h5000 + 32'(k); wstrb = 4'hF; wlast = 1'b0;
            wq.push_back('{10'(256 + k), 32'h5000 + 32'(k), 4'hF});
            @(negedge clk);
            check("rst_test_wready", 64'(wready), 64'd1);
            if (k < 5) begin
                @(posedge clk); #1;
            end
        end
        #1 rst_n = 1'b0;
        #1;
        check("midburst_rst_mem_we", 64'(mem_we), 64'd0);
        check("midburst_rst_bvalid", 64'(bvalid), 64'd0);
        check("midburst_rst_wready", 64'(wready), 64'd0);
        @(posedge clk); #1;
        wvalid = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        check("awready_after_release", 64'(awready), 64'd1);
        repeat (3) @(negedge clk);
        check("no_b_after_abort", 64'(bvalid), 64'd0);

        // Normal operation resumes after the abort.
        axi_write(32'h40, 1, 3'd2, 2'd1, 4'd11, 32'h7777_0000, -1, 1'b0, 1'b1);
        axi_read(32'h40, 1, 3'd2, 2'd1, 4'd11, 1'b0, 1'b0);

        repeat (2) @(negedge clk);
        check("write_queue_drained", 64'(wq.size()), 64'd0);
        check("read_queue_drained", 64'(rq.size()), 64'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
